// File: rtl/conv1d_sequencer_if.sv
// ---------------------------------------------------------------------------
// conv1d_sequencer_if
//   Output stream of the conv1d sequencer: one 32-bit accumulator per beat.
//
//   Handshake: a beat transfers on a rising clk edge where out_valid and
//   out_ready are both high. While out_valid is high, out_data is stable and
//   out_valid stays high until the beat transfers. out_ready may be driven
//   freely by the consumer and may depend on out_valid.
//
//   Signals:
//     out_valid  source -> sink  head entry present
//     out_ready  sink -> source  consumer takes out_data this cycle
//     out_data   source -> sink  head entry (32-bit accumulator)
//
//   Modports:
//     master  the sequencer (drives valid/data)
//     slave   the consumer (drives ready)
// ---------------------------------------------------------------------------
interface conv1d_sequencer_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/conv1d_sequencer.sv
// ---------------------------------------------------------------------------
// conv1d_sequencer
//   Controller in front of the conv1d CFU datapath. On start it walks
//   in_x_origin over num_outputs positions, issuing SET_ORIGIN / COMPUTE /
//   READ_ACC for each one and capturing the accumulator into a small
//   first-word-fall-through FIFO. While idle, the datapath command port is
//   handed to a host pass-through.
//
// Ports:
//   clk, reset_n           clock, synchronous active-low reset
//   host_cmd_valid/ready   host command request / forwarded this cycle
//   host_cmd/inp0/inp1     host command code, address, value
//   host_ret               datapath return value (always passed through)
//   start                  begin a sweep (only honoured in IDLE)
//   origin_start/step      signed first origin and increment (latched)
//   num_outputs            sweep length (latched); 0 gives an empty sweep
//   abort                  drop the sweep, return to IDLE, keep FIFO
//   busy, done             not-IDLE flag, one-cycle completion pulse
//   conv_cmd/inp0/inp1     command bus to the datapath
//   conv_ret               datapath return value
//   out_if                 accumulator output stream (valid/ready)
//   fifo_level             output FIFO occupancy
//   dbg_state              current FSM state encoding
// ---------------------------------------------------------------------------
module conv1d_sequencer #(
  parameter int         FIFO_DEPTH     = 4,
  parameter logic [6:0] CMD_NOP        = 7'd127,
  parameter logic [6:0] CMD_SET_ORIGIN = 7'd42,
  parameter logic [6:0] CMD_COMPUTE    = 7'd41,
  parameter logic [6:0] CMD_READ_ACC   = 7'd43
) (
  input  logic                          clk,
  input  logic                          reset_n,

  input  logic                          host_cmd_valid,
  output logic                          host_cmd_ready,
  input  logic [6:0]                    host_cmd,
  input  logic [31:0]                   host_inp0,
  input  logic [31:0]                   host_inp1,
  output logic [31:0]                   host_ret,

  input  logic                          start,
  input  logic [31:0]                   origin_start,
  input  logic [31:0]                   origin_step,
  input  logic [15:0]                   num_outputs,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,

  output logic [6:0]                    conv_cmd,
  output logic [31:0]                   conv_inp0,
  output logic [31:0]                   conv_inp1,
  input  logic [31:0]                   conv_ret,

  conv1d_sequencer_if.master            out_if,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [2:0]                    dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SET  = 3'd1,
    S_COMP = 3'd2,
    S_RD   = 3'd3,
    S_CAP  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t state, state_nx;

  // Sweep bookkeeping
  logic [31:0] cur_origin;
  logic [31:0] step_r;
  logic [15:0] num_r;
  logic [15:0] idx;
  logic        last_output;

  // Output FIFO
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_full, fifo_empty;
  logic        push, pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_level = wr_ptr - rd_ptr;

  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_data  = mem[rd_ptr[AW-1:0]];

  assign pop = out_if.out_valid && out_if.out_ready;
  // A full FIFO still accepts the capture when the head leaves in the same
  // cycle: the freed slot is the one being written. Abort beats the push.
  assign push = (state == S_CAP) && !abort && (!fifo_full || pop);

  // idx counts completed outputs, so idx+1 is the count after this push.
  assign last_output = ((idx + 16'd1) == num_r);

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign host_ret  = conv_ret;
  assign dbg_state = state;

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------------
  // FSM next state and datapath command drive
  // ---------------------------------------------------------------------
  always_comb begin
    state_nx       = state;
    conv_cmd       = CMD_NOP;
    conv_inp0      = 32'd0;
    conv_inp1      = 32'd0;
    host_cmd_ready = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = (num_outputs == 16'd0) ? S_DONE : S_SET;
        end else if (host_cmd_valid) begin
          conv_cmd       = host_cmd;
          conv_inp0      = host_inp0;
          conv_inp1      = host_inp1;
          host_cmd_ready = 1'b1;
        end
      end
      S_SET: begin
        conv_cmd  = CMD_SET_ORIGIN;
        conv_inp1 = cur_origin;
        state_nx  = S_COMP;
      end
      S_COMP: begin
        conv_cmd = CMD_COMPUTE;
        state_nx = S_RD;
      end
      S_RD: begin
        conv_cmd = CMD_READ_ACC;
        state_nx = S_CAP;
      end
      S_CAP: begin
        // NOP keeps conv_ret holding the registered accumulator while we
        // wait out back-pressure.
        if (push) begin
          state_nx = last_output ? S_DONE : S_SET;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    if (abort && (state != S_IDLE)) begin
      state_nx = S_IDLE;
    end
  end

  // ---------------------------------------------------------------------
  // Sweep counters
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur_origin <= 32'd0;
      step_r     <= 32'd0;
      num_r      <= 16'd0;
      idx        <= 16'd0;
    end else if ((state == S_IDLE) && start) begin
      cur_origin <= origin_start;
      step_r     <= origin_step;
      num_r      <= num_outputs;
      idx        <= 16'd0;
    end else if (push) begin
      idx        <= idx + 16'd1;
      cur_origin <= cur_origin + step_r;
    end
  end

  // ---------------------------------------------------------------------
  // FIFO pointers and storage
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= conv_ret;
    end
  end

endmodule

// File: doc/conv1d_sequencer.md
Name: conv1d_sequencer

Overview:
- Controller in front of the conv1d CFU datapath.
- On start, it sweeps in_x_origin over a run of output positions. For each position it issues the set-origin / compute / read command triple and pushes each 32-bit accumulator into a small output FIFO drained by a valid/ready consumer.
- While IDLE it arbitrates the datapath to a host pass-through port, used for buffer loads and parameter writes.

Parameters:
- FIFO_DEPTH, 4, output FIFO entries (power of two, >= 2).
- CMD_NOP, 7'd127, idle command driven to the datapath (decodes to no action).
- CMD_SET_ORIGIN, 7'd42, writes in_x_origin from inp1.
- CMD_COMPUTE, 7'd41, computes acc.
- CMD_READ_ACC, 7'd43, registers acc onto ret.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset.
- host_cmd_valid  in  1  host requests a datapath command this cycle.
- host_cmd_ready  out  1  host command forwarded this cycle.
- host_cmd  in  7  host command code.
- host_inp0  in  32  host address.
- host_inp1  in  32  host value.
- host_ret  out  32  conv_ret passed through.
- start  in  1  begin a sweep (sampled in IDLE only).
- origin_start  in  32  signed first in_x_origin; latched on start.
- origin_step  in  32  signed origin increment; latched on start.
- num_outputs  in  16  number of outputs in the sweep; latched on start.
- abort  in  1  terminate the sweep.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the sweep completes.
- conv_cmd  out  7  to datapath cmd.
- conv_inp0  out  32  to datapath inp0.
- conv_inp1  out  32  to datapath inp1.
- conv_ret  in  32  from datapath ret.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  32  FIFO head.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (reset_n=0 at posedge):
  - State IDLE.
  - FIFO emptied; fifo_level=0, out_valid=0.
  - done=0, busy=0.
  - Sweep counters cleared.
  - conv_cmd=CMD_NOP, conv_inp0=0, conv_inp1=0 (combinational outputs follow IDLE with no host request).
  - Reset mid-sweep discards everything; the datapath is not cleaned up.
- Arbitration (combinational):
  - In IDLE with host_cmd_valid=1 and start=0: conv_cmd/inp0/inp1 = host_cmd/inp0/inp1 and host_cmd_ready=1.
  - Otherwise host_cmd_ready=0. Outside IDLE the sequencer drives conv_*.
  - host_ret = conv_ret always.
  - start and host_cmd_valid in the same IDLE cycle: start wins.
- States:
  - IDLE:
    - Drives NOP.
    - start=1 latches origin_start/origin_step/num_outputs, then sets idx=0 and cur_origin=origin_start.
    - If num_outputs=0, go to DONE; else go to SET.
  - SET: conv_cmd=CMD_SET_ORIGIN, conv_inp1=cur_origin, conv_inp0=0. Next state COMP.
  - COMP: conv_cmd=CMD_COMPUTE. Next state RD.
  - RD: conv_cmd=CMD_READ_ACC. Next state CAP.
  - CAP:
    - conv_cmd=NOP; conv_ret is valid and held stable by the NOP.
    - The push succeeds if the FIFO is not full, or if a pop happens in the same cycle.
    - On push: idx++, cur_origin += origin_step (32-bit two's-complement wrap).
    - Then go to DONE if idx+1 == num_outputs, else SET.
    - If the FIFO is full and there is no pop: stay in CAP (back-pressure stall).
  - DONE: done=1 for exactly this cycle, NOP; next state IDLE.
- Throughput and latency:
  - 4 cycles per output when unstalled.
  - The first FIFO push occurs at the end of cycle 4 after the start cycle.
  - out_data of entry k is accumulated with in_x_origin = origin_start + k*origin_step.
- FIFO:
  - Pop when out_valid && out_ready.
  - Simultaneous push and pop leaves fifo_level unchanged.
  - Pops are allowed in any state, including IDLE and during reset-free abort.
  - First-word-fall-through: out_data is valid whenever out_valid=1.
- abort:
  - In any non-IDLE state, abort forces IDLE at the next edge with no done pulse.
  - In CAP, abort has priority over the push.
  - FIFO contents are retained. abort in IDLE is ignored.
- start while busy is ignored.
- The host must not change latched sweep inputs mid-sweep; they have no effect anyway.

Test Plan:
- Pass-through: in IDLE, host_cmd_valid=1, host_cmd=10, host_inp0=5, host_inp1=0x7F -> conv_cmd=10, conv_inp0=5, conv_inp1=0x7F, host_cmd_ready=1 in the same cycle. With start=1 in the same cycle -> host_cmd_ready=0.
- Basic sweep: origin_start=-4, origin_step=1, num_outputs=3, out_ready=1, datapath model returning origin*10 -> conv_cmd sequence 42,41,43,127 repeated ×3 with inp1=-4,-3,-2; FIFO pops -40,-30,-20; done pulses once at cycle 13; busy is low afterwards.
- Back-pressure: FIFO_DEPTH=4, num_outputs=6, out_ready=0 -> 4 entries pushed, then state sticks in CAP with conv_cmd=NOP and fifo_level=4. Raising out_ready for one cycle -> 5th push occurs in that pop cycle with level staying 4. Final order is preserved.
- Zero-length: num_outputs=0 -> no 41/42/43 issued; done is high on the cycle after start; FIFO is unchanged.
- Abort: abort asserted during the second COMP of a 5-output sweep -> IDLE next cycle, no done, fifo_level=1, conv_cmd=NOP.
- Reset mid-sweep with fifo_level=2 -> reset_n low for 1 cycle gives busy=0, fifo_level=0, out_valid=0. A new start is then accepted normally.
